// File: rtl/tour_cmd.sv
// Command sequencer between the UART command path and cmd_proc: passes UART
// commands through in idle, or replays the stored knight's tour as vertical/horizontal leg pairs.
module tour_cmd #(
    parameter int unsigned NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tour_go,
    output logic [4:0]  mv_indx,
    input  logic [7:0]  move,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp
);

    localparam int unsigned IDX_W = 5;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

    localparam logic [3:0] OP_VERT    = 4'h2;
    localparam logic [3:0] OP_HORZ    = 4'h3;
    localparam logic [7:0] HDG_NORTH  = 8'h00;
    localparam logic [7:0] HDG_SOUTH  = 8'h7F;
    localparam logic [7:0] HDG_EAST   = 8'hBF;
    localparam logic [7:0] HDG_WEST   = 8'h3F;
    localparam logic [7:0] RESP_DONE  = 8'hA5;
    localparam logic [7:0] RESP_BUSY  = 8'h5A;

    typedef enum logic [2:0] {
        IDLE,
        VERT,
        WAIT_V,
        HORZ,
        WAIT_H
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] mv_indx_q, mv_indx_d;

    logic             vert_south, horz_west;
    logic [3:0]       vert_sq, horz_sq;
    logic [15:0]      vert_cmd, horz_cmd;
    logic             last_move;

    // State and move index registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mv_indx_q <= '0;
        end else begin
            state_q   <= state_d;
            mv_indx_q <= mv_indx_d;
        end
    end

    // One-hot move decode; the lowest set bit wins, zero yields north/east with no squares
    always_comb begin
        vert_south = 1'b0;
        vert_sq    = 4'd0;
        horz_west  = 1'b0;
        horz_sq    = 4'd0;
        if (move[0]) begin
            vert_sq = 4'd2; horz_sq = 4'd1;
        end else if (move[1]) begin
            vert_sq = 4'd2; horz_west = 1'b1; horz_sq = 4'd1;
        end else if (move[2]) begin
            vert_sq = 4'd1; horz_west = 1'b1; horz_sq = 4'd2;
        end else if (move[3]) begin
            vert_south = 1'b1; vert_sq = 4'd1; horz_west = 1'b1; horz_sq = 4'd2;
        end else if (move[4]) begin
            vert_south = 1'b1; vert_sq = 4'd2; horz_west = 1'b1; horz_sq = 4'd1;
        end else if (move[5]) begin
            vert_south = 1'b1; vert_sq = 4'd2; horz_sq = 4'd1;
        end else if (move[6]) begin
            vert_south = 1'b1; vert_sq = 4'd1; horz_sq = 4'd2;
        end else if (move[7]) begin
            vert_sq = 4'd1; horz_sq = 4'd2;
        end
    end

    assign vert_cmd  = {OP_VERT, (vert_south ? HDG_SOUTH : HDG_NORTH), vert_sq};
    assign horz_cmd  = {OP_HORZ, (horz_west ? HDG_WEST : HDG_EAST), horz_sq};
    assign last_move = (mv_indx_q == LAST_IDX);
    assign mv_indx   = mv_indx_q;

    // Next state and outputs; resp must be valid alongside send_resp so it is decoded here
    always_comb begin
        state_d          = state_q;
        mv_indx_d        = mv_indx_q;
        cmd              = vert_cmd;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        resp             = RESP_BUSY;
        unique case (state_q)
            IDLE: begin
                cmd              = cmd_UART;
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
                resp             = RESP_DONE;
                if (tour_go) begin
                    mv_indx_d = '0;
                    state_d   = VERT;
                end
            end
            VERT: begin
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) state_d = WAIT_V;
            end
            WAIT_V: begin
                if (send_resp) state_d = HORZ;
            end
            HORZ: begin
                cmd     = horz_cmd;
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) state_d = WAIT_H;
            end
            WAIT_H: begin
                cmd = horz_cmd;
                if (last_move) resp = RESP_DONE;
                if (send_resp) begin
                    if (last_move) begin
                        state_d = IDLE;
                    end else begin
                        mv_indx_d = mv_indx_q + IDX_W'(1);
                        state_d   = VERT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
